can_frame_rx: RTL and testbench

Receive-only CAN 2.0A frame deserializer for the custom CAN node.
- Samples one bus bit per `can_clk` cycle from the node's bus-input pin and removes stuff bits.
- Parses a standard-format frame, checks the CRC-15 and drives the ACK slot.
- Presents a decoded frame (ID, RTR, DLC, payload) with a one-cycle valid strobe, or a one-cycle error strobe with a cause code.
- Replaces the ad-hoc post-frame destuffing pass currently done inside the node's transmit state machine.

---
 rtl/can_pkg.sv | 42 ++++
 rtl/can_crc15.sv | 19 +
 rtl/can_frame_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_can_frame_rx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// can_pkg: shared constants for the CAN 2.0A receive path (and future tx).
// Holds FSM state encodings, field lengths, error codes and a CRC-15 step.
package can_pkg;

  typedef logic [3:0] can_state_t;

  localparam can_state_t S_WAIT_IDLE = 4'd0;
  localparam can_state_t S_IDLE      = 4'd1;
  localparam can_state_t S_HDR       = 4'd2;
  localparam can_state_t S_DATA      = 4'd3;
  localparam can_state_t S_CRC       = 4'd4;
  localparam can_state_t S_CRC_DEL   = 4'd5;
  localparam can_state_t S_ACK       = 4'd6;
  localparam can_state_t S_ACK_DEL   = 4'd7;
  localparam can_state_t S_EOF       = 4'd8;
  localparam can_state_t S_ERROR     = 4'd9;

  localparam logic [14:0] CRC15_POLY = 15'h4599;

  localparam int ID_LEN      = 11;
  localparam int DLC_LEN     = 4;
  localparam int CRC_LEN     = 15;
  localparam int EOF_LEN     = 7;
  localparam int HDR_LEN     = ID_LEN + 3 + DLC_LEN;
  localparam int IDE_POS     = ID_LEN + 1;
  localparam int STUFF_LIMIT = 5;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_STUFF = 2'b01;
  localparam logic [1:0] ERR_FORM  = 2'b10;
  localparam logic [1:0] ERR_CRC   = 2'b11;

  function automatic logic [14:0] crc15_step(
    input logic [14:0] c,
    input logic        d
  );
    logic fb;
    fb = d ^ c[14];
    return {c[13:0], 1'b0} ^ (fb ? CRC15_POLY : 15'd0);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// can_crc15: serial CRC-15 register, one bit per enabled clock.
// Ports: clk, reset (sync, high), clr, en, din in; crc[14:0] out.
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [14:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || clr) crc <= '0;
    else if (en)      crc <= crc15_step(crc, din);
  end

endmodule

// File: rtl/can_frame_rx.sv
// can_frame_rx: CAN 2.0A frame deserializer with destuffing, CRC and ACK.
// Ports: can_clk, reset, can_lo_in in; ack_out, rx_* frame/error outputs.
module can_frame_rx
  import can_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int IDLE_BITS = 11
) (
  input  logic              can_clk,
  input  logic              reset,
  input  logic              can_lo_in,
  output logic              ack_out,
  output logic              rx_valid,
  output logic [10:0]       rx_id,
  output logic              rx_rtr,
  output logic [3:0]        rx_dlc,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_err,
  output logic [1:0]        rx_err_code
);

  localparam int LW = $clog2(DATA_W + 1);
  localparam int RW = $clog2(IDLE_BITS + 1);

  can_state_t        state;
  logic [RW-1:0]     rec_cnt;
  logic [LW-1:0]     cnt;
  logic [LW-1:0]     len;
  logic [LW-1:0]     len_n;
  logic [2:0]        run_len;
  logic              run_val;
  logic [13:0]       sh;
  logic [10:0]       id_q;
  logic              rtr_q;
  logic [3:0]        dlc_q;
  logic [3:0]        dlc_n;
  logic [DATA_W-1:0] data_q;
  logic              crc_bad;
  logic [14:0]       crc;

  logic b;
  logic idle;
  logic wait_st;
  logic sof;
  logic destuff_on;
  logic stuff_slot;
  logic stuff_err;
  logic bit_ok;
  logic crc_clr;
  logic crc_en;
  logic ide_bad;
  logic delim_bad;
  logic crc_fail;
  logic err_now;
  logic [1:0] err_code;

  assign b          = can_lo_in;
  assign idle       = rec_cnt >= RW'(IDLE_BITS);
  assign wait_st    = state == S_WAIT_IDLE || state == S_IDLE;
  assign sof        = wait_st && idle && !b;
  assign destuff_on = state == S_HDR || state == S_DATA
                   || state == S_CRC;

  // Sixth sample after a run of five is the stuff bit.
  assign stuff_slot = destuff_on && run_len == 3'(STUFF_LIMIT);
  assign stuff_err  = stuff_slot && b == run_val;
  assign bit_ok     = destuff_on && !stuff_slot;

  assign dlc_n = {sh[2:0], b};
  assign len_n = (rtr_q || dlc_n == 4'd0) ? '0
               : dlc_n[3] ? LW'(DATA_W)
               : LW'({dlc_n[2:0], 3'b000});

  assign crc_clr = wait_st && !sof;
  assign crc_en  = sof
                || (bit_ok && (state == S_HDR || state == S_DATA));

  assign ide_bad   = state == S_HDR && bit_ok
                  && cnt == LW'(IDE_POS) && b;
  assign delim_bad = (state == S_CRC_DEL || state == S_ACK_DEL
                   || state == S_EOF) && !b;
  assign crc_fail  = state == S_ACK_DEL && b && crc_bad;

  always_comb begin
    err_now  = 1'b0;
    err_code = ERR_NONE;
    unique case (1'b1)
      stuff_err: begin
        err_now  = 1'b1;
        err_code = ERR_STUFF;
      end
      ide_bad, delim_bad: begin
        err_now  = 1'b1;
        err_code = ERR_FORM;
      end
      crc_fail: begin
        err_now  = 1'b1;
        err_code = ERR_CRC;
      end
      default: ;
    endcase
  end

  can_crc15 u_crc (
    .clk   (can_clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (b),
    .crc   (crc)
  );

  always_ff @(posedge can_clk) begin
    if (reset)   rec_cnt <= '0;
    else if (!b) rec_cnt <= '0;
    else if (!idle) rec_cnt <= rec_cnt + 1'b1;
  end

  always_ff @(posedge can_clk) begin
    if (reset) begin
      state       <= S_WAIT_IDLE;
      cnt         <= '0;
      len         <= '0;
      run_val     <= 1'b0;
      run_len     <= '0;
      sh          <= '0;
      id_q        <= '0;
      rtr_q       <= 1'b0;
      dlc_q       <= '0;
      data_q      <= '0;
      crc_bad     <= 1'b0;
      ack_out     <= 1'b0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_id       <= '0;
      rx_rtr      <= 1'b0;
      rx_dlc      <= '0;
      rx_data     <= '0;
      rx_err_code <= ERR_NONE;
    end else begin
      ack_out  <= 1'b0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;

      if (sof) begin
        run_val <= 1'b0;
        run_len <= 3'd1;
      end else if (destuff_on) begin
        if (stuff_slot || b != run_val) begin
          run_val <= b;
          run_len <= 3'd1;
        end else begin
          run_len <= run_len + 3'd1;
        end
      end

      if (bit_ok) begin
        sh  <= {sh[12:0], b};
        cnt <= cnt + 1'b1;
      end

      if (err_now) begin
        state       <= S_ERROR;
        rx_err      <= 1'b1;
        rx_err_code <= err_code;
      end else begin
        case (state)
          S_WAIT_IDLE, S_IDLE: begin
            if (sof) begin
              state   <= S_HDR;
              cnt     <= '0;
              crc_bad <= 1'b0;
            end else if (idle) begin
              state <= S_IDLE;
            end
          end
          S_HDR: if (bit_ok) begin
            if (cnt == LW'(ID_LEN - 1)) id_q  <= {sh[9:0], b};
            if (cnt == LW'(ID_LEN))     rtr_q <= b;
            if (cnt == LW'(HDR_LEN - 1)) begin
              dlc_q <= dlc_n;
              len   <= len_n;
              cnt   <= '0;
              state <= (len_n == '0) ? S_CRC : S_DATA;
            end
          end
          S_DATA: if (bit_ok) begin
            data_q <= {data_q[DATA_W-2:0], b};
            if (cnt == len - 1'b1) begin
              cnt   <= '0;
              state <= S_CRC;
            end
          end
          S_CRC: if (bit_ok && cnt == LW'(CRC_LEN - 1)) begin
            crc_bad <= {sh, b} != crc;
            cnt     <= '0;
            state   <= S_CRC_DEL;
          end
          S_CRC_DEL: begin
            ack_out <= !crc_bad;
            state   <= S_ACK;
          end
          S_ACK: state <= S_ACK_DEL;
          S_ACK_DEL: begin
            cnt   <= '0;
            state <= S_EOF;
          end
          S_EOF: begin
            cnt <= cnt + 1'b1;
            if (cnt == LW'(EOF_LEN - 1)) begin
              rx_valid <= 1'b1;
              rx_id    <= id_q;
              rx_rtr   <= rtr_q;
              rx_dlc   <= dlc_q;
              // Payload sits in the low len bits; left-align it.
              // len == 0 shifts everything out, giving zero data.
              rx_data  <= data_q << (LW'(DATA_W) - len);
              state    <= S_IDLE;
            end
          end
          default: state <= S_WAIT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_frame_rx.sv
// tb_can_frame_rx: directed frames into can_frame_rx with fixed expectations.
// Bus is wired-AND of bench transmitter and DUT ack_out.
module tb_can_frame_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx = 1'b1;
  logic        can_lo;
  logic        ack_out;
  logic        rx_valid;
  logic [10:0] rx_id;
  logic        rx_rtr;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        rx_err;
  logic [1:0]  rx_err_code;

  int checks = 0;
  int errors = 0;
  int pos = 0;
  int n_ack, n_val, n_err, ack_pos, val_pos, err_pos;
  int n_both = 0;
  int base, n;
  logic fr[$];

  assign can_lo = tx & ~ack_out;

  always #5 clk = ~clk;

  can_frame_rx #(
    .DATA_W    (64),
    .IDLE_BITS (11)
  ) dut (
    .can_clk     (clk),
    .reset       (reset),
    .can_lo_in   (can_lo),
    .ack_out     (ack_out),
    .rx_valid    (rx_valid),
    .rx_id       (rx_id),
    .rx_rtr      (rx_rtr),
    .rx_dlc      (rx_dlc),
    .rx_data     (rx_data),
    .rx_err      (rx_err),
    .rx_err_code (rx_err_code)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    n_ack = 0; n_val = 0; n_err = 0;
    ack_pos = -1; val_pos = -1; err_pos = -1;
  endtask

  task automatic send_bit(input logic v);
    tx = v;
    @(posedge clk);
    #1;
    if (ack_out)  begin n_ack++; ack_pos = pos; end
    if (rx_valid) begin n_val++; val_pos = pos; end
    if (rx_err)   begin n_err++; err_pos = pos; end
    if (rx_valid && rx_err) n_both++;
    pos++;
  endtask

  task automatic send_idle(input int cnt);
    repeat (cnt) send_bit(1'b1);
  endtask

  task automatic send_frame(input int limit);
    int stop;
    base = pos;
    n = fr.size();
    stop = (limit < 0) ? n : limit;
    for (int i = 0; i < stop; i++) send_bit(fr[i]);
    tx = 1'b1;
  endtask

  task automatic build_frame(input logic [10:0] id, input logic rtr,
      input logic [3:0] dlc, input logic [63:0] data,
      input int crc_flip, input bit bad_stuff, input int eof_dom);
    logic raw[$];
    logic [14:0] c;
    logic fb, last, s;
    int nb, len;
    bit first;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = (rtr || dlc == 4'd0) ? 0 : (dlc > 4'd8 ? 64 : 8 * int'(dlc));
    for (int i = 0; i < nb; i++) raw.push_back(data[63 - i]);
    c = '0;
    for (int k = 0; k < raw.size(); k++) begin
      fb = raw[k] ^ c[14];
      c = {c[13:0], 1'b0};
      if (fb) c = c ^ 15'h4599;
    end
    if (crc_flip >= 0) c[crc_flip] = ~c[crc_flip];
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    fr.delete();
    len = 0;
    last = 1'b1;
    first = 1'b1;
    for (int k = 0; k < raw.size(); k++) begin
      fr.push_back(raw[k]);
      if (len > 0 && raw[k] == last) len++;
      else begin
        last = raw[k];
        len = 1;
      end
      if (len == 5 && k < raw.size() - 1) begin
        s = (bad_stuff && first) ? last : ~last;
        first = 1'b0;
        fr.push_back(s);
        last = s;
        len = 1;
      end
    end
    fr.push_back(1'b1);
    fr.push_back(1'b1);
    fr.push_back(1'b1);
    for (int i = 1; i <= 7; i++) fr.push_back(i == eof_dom ? 1'b0 : 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"},  64'(ack_out), 64'd0);
    check({tag, "_val"},  64'(rx_valid), 64'd0);
    check({tag, "_err"},  64'(rx_err), 64'd0);
    check({tag, "_id"},   64'(rx_id), 64'd0);
    check({tag, "_rtr"},  64'(rx_rtr), 64'd0);
    check({tag, "_dlc"},  64'(rx_dlc), 64'd0);
    check({tag, "_data"}, rx_data, 64'd0);
    check({tag, "_code"}, 64'(rx_err_code), 64'd0);
  endtask

  initial begin
    mon_clear();
    reset = 1'b1;
    tx = 1'b1;
    @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b0;

    // 1: ID 0x7F8, DLC 1, data 0x89
    mon_clear();
    send_idle(12);
    build_frame(11'h7F8, 1'b0, 4'd1, 64'h89 << 56, -1, 0, 0);
    send_frame(-1);
    check("s1_ack_cnt", 64'(n_ack), 64'd1);
    check("s1_ack_pos", 64'(ack_pos - base), 64'(n - 10));
    check("s1_val_cnt", 64'(n_val), 64'd1);
    check("s1_val_pos", 64'(val_pos - base), 64'(n - 1));
    check("s1_err_cnt", 64'(n_err), 64'd0);
    check("s1_id", 64'(rx_id), 64'h7F8);
    check("s1_rtr", 64'(rx_rtr), 64'd0);
    check("s1_dlc", 64'(rx_dlc), 64'd1);
    check("s1_data", rx_data, 64'h8900_0000_0000_0000);

    // 2a: ID 0x7FF, DLC 0, back-to-back after 3-bit intermission
    mon_clear();
    send_idle(3);
    build_frame(11'h7FF, 1'b0, 4'd0, 64'd0, -1, 0, 0);
    send_frame(-1);
    check("s2a_val_cnt", 64'(n_val), 64'd1);
    check("s2a_err_cnt", 64'(n_err), 64'd0);
    check("s2a_id", 64'(rx_id), 64'h7FF);
    check("s2a_dlc", 64'(rx_dlc), 64'd0);
    check("s2a_data", rx_data, 64'd0);

    // 2b: first stuff bit replaced by a sixth recessive
    mon_clear();
    send_idle(3);
    build_frame(11'h7FF, 1'b0, 4'd0, 64'd0, -1, 1, 0);
    send_frame(7);
    send_idle(12);
    check("s2b_err_cnt", 64'(n_err), 64'd1);
    check("s2b_err_pos", 64'(err_pos - base), 64'd6);
    check("s2b_code", 64'(rx_err_code), 64'd1);
    check("s2b_val_cnt", 64'(n_val), 64'd0);

    // 2c: clean frame afterwards
    mon_clear();
    build_frame(11'h123, 1'b0, 4'd2, 64'hABCD << 48, -1, 0, 0);
    send_frame(-1);
    check("s2c_val_cnt", 64'(n_val), 64'd1);
    check("s2c_err_cnt", 64'(n_err), 64'd0);
    check("s2c_id", 64'(rx_id), 64'h123);
    check("s2c_dlc", 64'(rx_dlc), 64'd2);
    check("s2c_data", rx_data, 64'hABCD_0000_0000_0000);
    check("s2c_code_hold", 64'(rx_err_code), 64'd1);

    // 3: one CRC bit flipped
    mon_clear();
    send_idle(12);
    build_frame(11'h7F8, 1'b0, 4'd1, 64'h89 << 56, 0, 0, 0);
    send_frame(-1);
    check("s3_ack_cnt", 64'(n_ack), 64'd0);
    check("s3_err_cnt", 64'(n_err), 64'd1);
    check("s3_err_pos", 64'(err_pos - base), 64'(n - 8));
    check("s3_code", 64'(rx_err_code), 64'd3);
    check("s3_val_cnt", 64'(n_val), 64'd0);
    check("s3_id_hold", 64'(rx_id), 64'h123);

    // 4: EOF bit 3 dominant
    mon_clear();
    send_idle(12);
    build_frame(11'h7F8, 1'b0, 4'd1, 64'h89 << 56, -1, 0, 3);
    send_frame(-1);
    check("s4_ack_cnt", 64'(n_ack), 64'd1);
    check("s4_err_cnt", 64'(n_err), 64'd1);
    check("s4_err_pos", 64'(err_pos - base), 64'(n - 5));
    check("s4_code", 64'(rx_err_code), 64'd2);
    check("s4_val_cnt", 64'(n_val), 64'd0);

    // 6: DLC 15 with 8 bytes, then RTR frame back-to-back
    mon_clear();
    send_idle(12);
    build_frame(11'h555, 1'b0, 4'd15, 64'h0102030405060708, -1, 0, 0);
    send_frame(-1);
    check("s6a_val_cnt", 64'(n_val), 64'd1);
    check("s6a_id", 64'(rx_id), 64'h555);
    check("s6a_dlc", 64'(rx_dlc), 64'd15);
    check("s6a_data", rx_data, 64'h0102030405060708);
    mon_clear();
    send_idle(3);
    build_frame(11'h2A5, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 0);
    send_frame(-1);
    check("s6b_val_cnt", 64'(n_val), 64'd1);
    check("s6b_id", 64'(rx_id), 64'h2A5);
    check("s6b_rtr", 64'(rx_rtr), 64'd1);
    check("s6b_dlc", 64'(rx_dlc), 64'd4);
    check("s6b_data", rx_data, 64'd0);

    // 5: reset during the data field
    mon_clear();
    send_idle(12);
    build_frame(11'h7F8, 1'b0, 4'd1, 64'h89 << 56, -1, 0, 0);
    send_frame(24);
    reset = 1'b1;
    tx = 1'b1;
    @(posedge clk);
    #1;
    check_zero("s5_rst");
    reset = 1'b0;
    mon_clear();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_idle(11);
    send_frame(-1);
    check("s5_err_cnt", 64'(n_err), 64'd0);
    check("s5_val_cnt", 64'(n_val), 64'd1);
    check("s5_id", 64'(rx_id), 64'h7F8);
    check("s5_data", rx_data, 64'h8900_0000_0000_0000);

    check("excl", 64'(n_both), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
